// File: rtl/uart_rx_core_if.sv
// UART receiver port bundle: serial line, clear pulse, data and status.
// The receiver core uses the slave side; the processor uses master.
interface uart_rx_core_if;
  logic       rx;
  logic       rx_clr;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output rx, rx_clr,
    input  rx_data, rx_flag, overrun,
    input  frame_err, parity_err, busy
  );

  modport slave (
    input  rx, rx_clr,
    output rx_data, rx_flag, overrun,
    output frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver with sticky status flags.
// Define UART_RX_PARITY_EN for an even-parity bit after the data.
module uart_rx_core #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input logic     clk,
  input logic     rst,
  uart_rx_core_if.slave bus
);
  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] CNT_END = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          flag_q, flag_d;
  logic          ovr_q, ovr_d;
  logic          fe_q, fe_d;
  logic          s1, rx_s;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          pe_q, pe_d;
`endif

  // Two-flop synchronizer; idles high so reset never fakes a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= bus.rx;
      rx_s <= s1;
    end
  end

  // State register and receive datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  // Next-state logic; a clear is applied first so a byte
  // completing in the same cycle overrides it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    flag_d  = flag_q;
    ovr_d   = ovr_q;
    fe_d    = fe_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = pe_q;
`endif
    if (bus.rx_clr) begin
      flag_d = 1'b0;
      ovr_d  = 1'b0;
      fe_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d   = 1'b0;
`endif
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_END) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = sh_q;
            flag_d  = 1'b1;
            ovr_d   = bus.rx_clr ? 1'b0 : (ovr_q | flag_q);
`ifdef UART_RX_PARITY_EN
            if (^{sh_q, par_q}) pe_d = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_flag   = flag_q;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = fe_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = pe_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receiver for the processor's serial port: the receiving end of the UART_Tx/UART_Rx pair exported by the RISC-V multi-cycle top. It samples an asynchronous 8N1 line, assembles bytes LSB first, and holds each received byte in a data register with sticky status flags until the memory-mapped UART peripheral clears them. With the processor's UART_Tx looped to UART_Rx, bytes the core transmits come back through this block.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate in bit/s; CPB = CLK_FREQ/BAUD_RATE (integer division, must be ≥ 4); HALF = CPB/2
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_clr  input  1  one-cycle pulse from the processor; clears rx_flag, overrun, frame_err and parity_err
- rx_data  output  8  last correctly framed byte, held until the next one
- rx_flag  output  1  sticky "byte available"
- overrun  output  1  sticky; a byte completed while rx_flag was already 1
- frame_err  output  1  sticky; stop bit sampled low
- parity_err  output  1  sticky; parity mismatch (constant 0 when parity is compiled out)
- busy  output  1  high in every state except IDLE

## Operation
- rx passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized rx_s.
- Baud counter cnt counts from 0 to its terminal value, then resets to 0. Bit index counts 0..7.
- IDLE: rx_s == 0 -> START, cnt = 0.
- START: at cnt == HALF-1, if rx_s == 0 -> DATA with cnt = 0; otherwise (glitch) -> IDLE.
- DATA: at cnt == CPB-1, shift rx_s into the MSB of the shift register (shift right) and increment the index. After the 8th bit -> PARITY if enabled, else STOP.
- PARITY: at cnt == CPB-1, capture the parity bit -> STOP.
- STOP: at cnt == CPB-1, sample rx_s:
  - rx_s == 1: load rx_data, set rx_flag; if rx_flag was already 1, set overrun (rx_data is overwritten); -> IDLE.
  - rx_s == 0: set frame_err; rx_data and rx_flag are unchanged -> BREAK.
- BREAK: wait for rx_s == 1 -> IDLE. A held-low line therefore produces one frame error, not repeated frames.
- rx_clr in the same cycle as a successful STOP sample: the new byte wins. rx_flag = 1, overrun = 0, and the other flags are cleared.
- rx_clr has no effect on the receive state machine.
- Reset (async, any time including mid-frame): state IDLE, cnt 0, index 0, shift register 0, rx_data 8'h00, rx_flag 0, overrun 0, frame_err 0, parity_err 0, busy 0, synchronizer 1. The first falling edge after reset release starts a new frame.

## Timing
- Bit centres are sampled at HALF + n·CPB cycles after start detection.
- rx_flag rises between 9·CPB+HALF and 9·CPB+HALF+4 cycles after the rx falling edge at the pin. With parity enabled, add CPB.
- rx_data and rx_flag update on the same clock edge. Flags respond to rx_clr on the next edge.
- Idle-high time between frames is not required: a start bit right after the stop-bit centre is detected.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state present, 9 bits follow the start bit.
  - parity_err is set at stop completion if XOR(data, parity bit) ≠ 0 (even parity).
  - The byte is still loaded and rx_flag still set.
- Undefined: 8N1 frame, no PARITY state, parity_err tied 0.

## Test plan
- CLK_FREQ=1600, BAUD_RATE=100 (CPB=16); send 8'hA5 8N1 -> rx_data = 8'hA5 and rx_flag = 1 within the timing window; all error flags 0.
- Send 8'h3C then 8'hC3 without rx_clr -> rx_data = 8'hC3, overrun = 1. Then rx_clr -> rx_flag = 0, overrun = 0.
- Low glitch of 4 cycles on idle rx -> returns to IDLE, busy drops, rx_flag stays 0.
- Frame 8'h55 with stop bit forced low, line held low for 40 bit times -> frame_err = 1 exactly once; rx_data unchanged; next valid 8'h0F is received after the line returns high.
- Assert rst during bit 4 of a frame -> all outputs at reset values immediately. Next full frame 8'h81 is received correctly.
- With UART_RX_PARITY_EN: 8'h07 with parity 1 -> parity_err 0. With parity 0 -> parity_err 1 and rx_data = 8'h07.
